jpeg_top: RTL and testbench
===========================

# jpeg_top

Parallel 16-lane lifting datapath for the JPEG-2000 5/3 wavelet engine. It holds three 144-bit sample-row memories (left/same/right), a 9-bit result memory and an 80-bit flag memory. One request performs a predict or update lifting step on 16 packed 9-bit samples at once. It also provides the significance-count and coordinate helpers used by the tile sequencer.

## Interface
- ADDR_W, 10, address width of all internal memories (depth 2^ADDR_W)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- left_s_i, sam_s_i, right_s_i  in  144 each  16 packed 9-bit signed samples; lane i = bits [9i+8:9i]
- flgs_s_i  in  80  16 packed 5-bit lane flags; lane i = bits [5i+4:5i]
- update_s  in  1  lifting request, sampled each clock
- noupdate_s  out  1  registered idle indicator
- row_ind, col_ind  in  10 each  current row and column index
- ma_row, ma_col  in  4 each  log2 of tile height and width
- flat_lf, flat_sa, flat_rt  out  144 each  registered lifting outputs
- z  in  9  signed offset
- x  in  10  base coordinate
- res_out_x  out  10  registered x + sext(z)
- bits_in_sig  in  10  significance bit vector
- vv  out  9  combinational population count of bits_in_sig
- din_lf, din_sa, din_rt  in  144; addr_lf, addr_sa, addr_rt  in  10; we_lf, we_sa, we_rt  in  1; dout_lf, dout_sa, dout_rt  out  144  row memories
- din_res  in  9; addr_res  in  10; we_res  in  1; dout_res  out  9  result memory
- addr_flgs  in  10; dout_flgs  out  80  flag memory read port

## Operation
- Row memories (lf/sa/rt) and the result memory: synchronous write when we_* = 1 at addr_*. Read is registered, with read-before-write ordering on the same address.
- Flag memory: written with flgs_s_i at addr_flgs on each accepted update. Read is registered at addr_flgs.
- vv = number of 1 bits in bits_in_sig (0..10), zero-extended to 9 bits. It is purely combinational.
- An update is accepted when update_s = 1 and row_ind < 2^ma_row. Otherwise it is suppressed: flat_* hold their values, no flag-memory write occurs, and noupdate_s stays 1.
- Per lane, for an accepted update: L = left lane, S = same lane, R = right lane, f = flag[2:0]. Flag bits [4:3] are reserved and ignored.
  - f=7, forward predict: S − ((L+R)>>>1)
  - f=5, forward update: S + ((L+R+2)>>>2)
  - f=6, inverse predict: S + ((L+R)>>>1)
  - f=4, inverse update: S − ((L+R+2)>>>2)
  - any other f: S passes through unchanged.
- Lifting arithmetic is signed and 11 bits wide internally. The result is truncated (wrapped) to 9 bits.
- On accept, flat_sa receives the lifting result. flat_lf and flat_rt receive the effective L and R values (after edge mirroring).
- res_out_x is registered every cycle as (x + sign-extended z) mod 1024.

## Timing
- Reset, applied on a clock edge with rst_n = 0: flat_* = 0, res_out_x = 0, noupdate_s = 1, dout_* = 0. Memory contents are not cleared.
- Memory read latency is 1 cycle.
- Update latency is 1 cycle: flat_* are valid on the edge after update_s is sampled.
- noupdate_s is 0 for exactly the cycle following an accepted update and is 1 otherwise.
- If update_s is held high, every cycle is a new accepted request and noupdate_s stays 0.
- Reset asserted in the same cycle as update_s: reset wins and the update is dropped.

## Configuration
- JPEG_EDGE_MIRROR_EN defined: symmetric extension is applied per lane.
  - If col_ind == 0, L is replaced by R.
  - If col_ind == 2^ma_col − 1, R is replaced by L.
  - If both conditions hold, L and R are used unchanged.
- JPEG_EDGE_MIRROR_EN undefined: L and R are always used as given.

## Test plan
- Memory write/read:
  - Write din_lf = 144'h5229138a452291389c4e271389c5227148a4 at addr 0 with we_lf = 1.
  - Read it back: dout_lf equals the written value one cycle later. Repeat for the sa and rt memories.
- Forward predict:
  - Apply lane-0 samples L = S = R = 9'h0A4, flgs_s_i = 7, and pulse update_s.
  - Next cycle: flat_sa lane 0 = 0; lanes 1–15 equal sam_s_i unchanged; noupdate_s = 0 for one cycle, then 1.
- Forward update:
  - Apply L = 4, R = 6, S = 10, f = 5.
  - Expect lane result 13. Repeat with f = 4: expect 7.
- Significance count:
  - bits_in_sig = 10'h3FF gives vv = 10; 10'h3FE gives vv = 9.
  - Writing vv to din_res with we_res = 1 and reading it back returns the same value.
- Boundary handling:
  - row_ind = 16, ma_row = 4: update suppressed, flat_* hold, noupdate_s stays 1.
  - With JPEG_EDGE_MIRROR_EN defined: col_ind = 0, L = 0, R = 8, S = 8, f = 7 gives lane result 0.
- Reset and coordinates:
  - x = 10'h3FF, z = 9'h001 gives res_out_x = 0, showing wrap-around.
  - Asserting rst_n = 0 during an update clears flat_* and sets noupdate_s = 1.

Source files
------------

// File: rtl/jpeg_top_if.sv
// Signal bundle for jpeg_top: lifting request and results, coordinate helpers and memory ports.
interface jpeg_top_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [143:0]      left_s_i;
    logic [143:0]      sam_s_i;
    logic [143:0]      right_s_i;
    logic [79:0]       flgs_s_i;
    logic              update_s;
    logic              noupdate_s;
    logic [9:0]        row_ind;
    logic [9:0]        col_ind;
    logic [3:0]        ma_row;
    logic [3:0]        ma_col;
    logic [143:0]      flat_lf;
    logic [143:0]      flat_sa;
    logic [143:0]      flat_rt;
    logic [8:0]        z;
    logic [9:0]        x;
    logic [9:0]        res_out_x;
    logic [9:0]        bits_in_sig;
    logic [8:0]        vv;
    logic [143:0]      din_lf;
    logic [143:0]      din_sa;
    logic [143:0]      din_rt;
    logic [ADDR_W-1:0] addr_lf;
    logic [ADDR_W-1:0] addr_sa;
    logic [ADDR_W-1:0] addr_rt;
    logic              we_lf;
    logic              we_sa;
    logic              we_rt;
    logic [143:0]      dout_lf;
    logic [143:0]      dout_sa;
    logic [143:0]      dout_rt;
    logic [8:0]        din_res;
    logic [ADDR_W-1:0] addr_res;
    logic              we_res;
    logic [8:0]        dout_res;
    logic [ADDR_W-1:0] addr_flgs;
    logic [79:0]       dout_flgs;

    modport master (
        output left_s_i, sam_s_i, right_s_i, flgs_s_i, update_s, row_ind, col_ind, ma_row,
               ma_col, z, x, bits_in_sig, din_lf, din_sa, din_rt, addr_lf, addr_sa, addr_rt,
               we_lf, we_sa, we_rt, din_res, addr_res, we_res, addr_flgs,
        input  noupdate_s, flat_lf, flat_sa, flat_rt, res_out_x, vv, dout_lf, dout_sa,
               dout_rt, dout_res, dout_flgs
    );

    modport slave (
        input  left_s_i, sam_s_i, right_s_i, flgs_s_i, update_s, row_ind, col_ind, ma_row,
               ma_col, z, x, bits_in_sig, din_lf, din_sa, din_rt, addr_lf, addr_sa, addr_rt,
               we_lf, we_sa, we_rt, din_res, addr_res, we_res, addr_flgs,
        output noupdate_s, flat_lf, flat_sa, flat_rt, res_out_x, vv, dout_lf, dout_sa,
               dout_rt, dout_res, dout_flgs
    );
endinterface

// File: rtl/jpeg_top.sv
// jpeg_top: 16-lane JPEG-2000 5/3 lifting datapath with row, result and flag memories.
// Define JPEG_EDGE_MIRROR_EN to enable per-lane symmetric edge extension.
module jpeg_top #(
    parameter int unsigned ADDR_W = 10
) (
    input logic       clk,
    input logic       rst_n,
    jpeg_top_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned Lanes = 16;

    function automatic logic [8:0] lift(input logic [8:0] l, input logic [8:0] s,
                                        input logic [8:0] r, input logic [2:0] f);
        logic signed [10:0] ls, ss, rs, pr, up, res;
        ls = {{2{l[8]}}, l};
        ss = {{2{s[8]}}, s};
        rs = {{2{r[8]}}, r};
        pr = (ls + rs) >>> 1;
        up = (ls + rs + 11'sd2) >>> 2;
        case (f)
            3'd7:    res = ss - pr;
            3'd5:    res = ss + up;
            3'd6:    res = ss + pr;
            3'd4:    res = ss - up;
            default: res = ss;
        endcase
        return res[8:0];
    endfunction

    logic [143:0] mem_lf   [Depth];
    logic [143:0] mem_sa   [Depth];
    logic [143:0] mem_rt   [Depth];
    logic [8:0]   mem_res  [Depth];
    logic [79:0]  mem_flgs [Depth];

    logic [143:0] dout_lf_q, dout_sa_q, dout_rt_q;
    logic [8:0]   dout_res_q;
    logic [79:0]  dout_flgs_q;

    logic [143:0] flat_lf_q, flat_sa_q, flat_rt_q;
    logic [143:0] flat_lf_d, flat_sa_d, flat_rt_d;
    logic         noupdate_q;
    logic [9:0]   res_out_x_q, res_out_x_d;
    logic [8:0]   vv_d;
    logic         accept;
    logic         col_first, col_last;
    logic [8:0]   lane_l, lane_r;

    // Reset drops a coincident request so no flag write or result update leaks through.
    assign accept = rst_n && bus.update_s && ({7'd0, bus.row_ind} < (17'd1 << bus.ma_row));

`ifdef JPEG_EDGE_MIRROR_EN
    assign col_first = (bus.col_ind == 10'd0);
    assign col_last  = ({7'd0, bus.col_ind} == ((17'd1 << bus.ma_col) - 17'd1));
`else
    logic unused_edge;
    assign col_first   = 1'b0;
    assign col_last    = 1'b0;
    assign unused_edge = ^{bus.col_ind, bus.ma_col};
`endif

    always_comb begin
        flat_lf_d = '0;
        flat_sa_d = '0;
        flat_rt_d = '0;
        lane_l    = '0;
        lane_r    = '0;
        for (int i = 0; i < int'(Lanes); i++) begin
            lane_l = bus.left_s_i[9*i +: 9];
            lane_r = bus.right_s_i[9*i +: 9];
            // A single-column tile is both first and last; extension then cancels out.
            if (col_first && !col_last) begin
                lane_l = bus.right_s_i[9*i +: 9];
            end else if (col_last && !col_first) begin
                lane_r = bus.left_s_i[9*i +: 9];
            end
            flat_lf_d[9*i +: 9] = lane_l;
            flat_rt_d[9*i +: 9] = lane_r;
            flat_sa_d[9*i +: 9] = lift(lane_l, bus.sam_s_i[9*i +: 9], lane_r,
                                       bus.flgs_s_i[5*i +: 3]);
        end
    end

    always_comb begin
        vv_d = '0;
        for (int i = 0; i < 10; i++) begin
            vv_d = vv_d + {8'd0, bus.bits_in_sig[i]};
        end
    end

    assign res_out_x_d = bus.x + {bus.z[8], bus.z};

    // Storage arrays are never cleared; only the read registers see reset.
    always_ff @(posedge clk) begin
        if (bus.we_lf) mem_lf[bus.addr_lf] <= bus.din_lf;
        if (bus.we_sa) mem_sa[bus.addr_sa] <= bus.din_sa;
        if (bus.we_rt) mem_rt[bus.addr_rt] <= bus.din_rt;
        if (bus.we_res) mem_res[bus.addr_res] <= bus.din_res;
        if (accept) mem_flgs[bus.addr_flgs] <= bus.flgs_s_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_lf_q   <= '0;
            dout_sa_q   <= '0;
            dout_rt_q   <= '0;
            dout_res_q  <= '0;
            dout_flgs_q <= '0;
        end else begin
            dout_lf_q   <= mem_lf[bus.addr_lf];
            dout_sa_q   <= mem_sa[bus.addr_sa];
            dout_rt_q   <= mem_rt[bus.addr_rt];
            dout_res_q  <= mem_res[bus.addr_res];
            dout_flgs_q <= mem_flgs[bus.addr_flgs];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flat_lf_q   <= '0;
            flat_sa_q   <= '0;
            flat_rt_q   <= '0;
            noupdate_q  <= 1'b1;
            res_out_x_q <= '0;
        end else begin
            noupdate_q  <= !accept;
            res_out_x_q <= res_out_x_d;
            if (accept) begin
                flat_lf_q <= flat_lf_d;
                flat_sa_q <= flat_sa_d;
                flat_rt_q <= flat_rt_d;
            end
        end
    end

    assign bus.flat_lf    = flat_lf_q;
    assign bus.flat_sa    = flat_sa_q;
    assign bus.flat_rt    = flat_rt_q;
    assign bus.noupdate_s = noupdate_q;
    assign bus.res_out_x  = res_out_x_q;
    assign bus.vv         = vv_d;
    assign bus.dout_lf    = dout_lf_q;
    assign bus.dout_sa    = dout_sa_q;
    assign bus.dout_rt    = dout_rt_q;
    assign bus.dout_res   = dout_res_q;
    assign bus.dout_flgs  = dout_flgs_q;
endmodule

// File: tb/tb_jpeg_top.sv
// Self-checking bench for jpeg_top: directed steps plus randomized traffic against an
// arithmetic reference model of the lifting rules and memories.
module tb_jpeg_top;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jpeg_top_if bus ();
    jpeg_top dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    logic [143:0] e_lf = '0, e_sa = '0, e_rt = '0;
    logic         e_nu = 1'b1;
    logic [9:0]   e_x = '0;
    logic [143:0] m_lf [int];
    logic [143:0] m_sa [int];
    logic [143:0] m_rt [int];
    logic [8:0]   m_res [int];
    logic [79:0]  m_fl [int];

    localparam logic [143:0] LfConst = 144'h5229138a452291389c4e271389c5227148a4;

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sx9(input logic [8:0] a);
        return int'($signed(a));
    endfunction

    function automatic logic [8:0] wrap9(input int v);
        int m;
        m = ((v % 512) + 512) % 512;
        return m[8:0];
    endfunction

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_lanes();
        int l, s, r, f, v;
        for (int i = 0; i < 16; i++) begin
            l = sx9(bus.left_s_i[9*i +: 9]);
            s = sx9(bus.sam_s_i[9*i +: 9]);
            r = sx9(bus.right_s_i[9*i +: 9]);
            f = int'(bus.flgs_s_i[5*i +: 3]);
`ifdef JPEG_EDGE_MIRROR_EN
            begin
                bit first, last;
                first = (bus.col_ind == 0);
                last  = (int'(bus.col_ind) == (1 << int'(bus.ma_col)) - 1);
                if (first && !last) l = r;
                else if (last && !first) r = l;
            end
`endif
            if (f == 7) v = s - fdiv(l + r, 2);
            else if (f == 5) v = s + fdiv(l + r + 2, 4);
            else if (f == 6) v = s + fdiv(l + r, 2);
            else if (f == 4) v = s - fdiv(l + r + 2, 4);
            else v = s;
            e_lf[9*i +: 9] = wrap9(l);
            e_rt[9*i +: 9] = wrap9(r);
            e_sa[9*i +: 9] = wrap9(v);
        end
    endtask

    // One clock: predict every registered output from current inputs, then compare.
    task automatic cycle();
        bit           acc, kl, ks, kr, kq, kf;
        logic [143:0] dl, ds, dr;
        logic [8:0]   dq;
        logic [79:0]  df;
        int           sx;
        #1;
        check("vv", 144'(bus.vv), 144'($countones(bus.bits_in_sig)));
        acc = rst_n && bus.update_s && (int'(bus.row_ind) < (1 << int'(bus.ma_row)));
        kl = !rst_n || m_lf.exists(int'(bus.addr_lf));
        ks = !rst_n || m_sa.exists(int'(bus.addr_sa));
        kr = !rst_n || m_rt.exists(int'(bus.addr_rt));
        kq = !rst_n || m_res.exists(int'(bus.addr_res));
        kf = !rst_n || m_fl.exists(int'(bus.addr_flgs));
        dl = '0; ds = '0; dr = '0; dq = '0; df = '0;
        if (rst_n && kl) dl = m_lf[int'(bus.addr_lf)];
        if (rst_n && ks) ds = m_sa[int'(bus.addr_sa)];
        if (rst_n && kr) dr = m_rt[int'(bus.addr_rt)];
        if (rst_n && kq) dq = m_res[int'(bus.addr_res)];
        if (rst_n && kf) df = m_fl[int'(bus.addr_flgs)];
        if (bus.we_lf) m_lf[int'(bus.addr_lf)] = bus.din_lf;
        if (bus.we_sa) m_sa[int'(bus.addr_sa)] = bus.din_sa;
        if (bus.we_rt) m_rt[int'(bus.addr_rt)] = bus.din_rt;
        if (bus.we_res) m_res[int'(bus.addr_res)] = bus.din_res;
        if (acc) m_fl[int'(bus.addr_flgs)] = bus.flgs_s_i;
        if (!rst_n) begin
            e_lf = '0; e_sa = '0; e_rt = '0; e_nu = 1'b1; e_x = '0;
        end else begin
            if (acc) model_lanes();
            e_nu = !acc;
            sx = int'(bus.x) + sx9(bus.z);
            sx = ((sx % 1024) + 1024) % 1024;
            e_x = sx[9:0];
        end
        @(posedge clk);
        #1;
        check("flat_lf", bus.flat_lf, e_lf);
        check("flat_sa", bus.flat_sa, e_sa);
        check("flat_rt", bus.flat_rt, e_rt);
        check("noupdate", 144'(bus.noupdate_s), 144'(e_nu));
        check("res_out_x", 144'(bus.res_out_x), 144'(e_x));
        if (kl) check("dout_lf", bus.dout_lf, dl);
        if (ks) check("dout_sa", bus.dout_sa, ds);
        if (kr) check("dout_rt", bus.dout_rt, dr);
        if (kq) check("dout_res", 144'(bus.dout_res), 144'(dq));
        if (kf) check("dout_flgs", 144'(bus.dout_flgs), 144'(df));
    endtask

    function automatic logic [143:0] rnd144();
        return 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.left_s_i = rnd144(); bus.sam_s_i = rnd144(); bus.right_s_i = rnd144();
        bus.flgs_s_i = 80'h7777_7777_7777_7777_7777;
        bus.update_s = 1'b1; bus.row_ind = '0; bus.col_ind = 10'd5;
        bus.ma_row = 4'd4; bus.ma_col = 4'd9;
        bus.z = 9'h01f; bus.x = 10'h155; bus.bits_in_sig = 10'h2a5;
        bus.din_lf = '0; bus.din_sa = '0; bus.din_rt = '0;
        bus.addr_lf = '0; bus.addr_sa = '0; bus.addr_rt = '0;
        bus.we_lf = 1'b0; bus.we_sa = 1'b0; bus.we_rt = 1'b0;
        bus.din_res = '0; bus.addr_res = '0; bus.we_res = 1'b0; bus.addr_flgs = 10'd1;

        cycle();
        cycle();
        check("rst_noupdate", 144'(bus.noupdate_s), 144'(1'b1));
        check("rst_flat_sa", bus.flat_sa, 144'd0);
        rst_n = 1'b1;
        bus.update_s = 1'b0;

        // Row memory write, read-before-write, read-back.
        bus.we_lf = 1'b1; bus.din_lf = LfConst;
        bus.we_sa = 1'b1; bus.din_sa = rnd144();
        bus.we_rt = 1'b1; bus.din_rt = rnd144();
        cycle();
        bus.we_lf = 1'b0; bus.we_sa = 1'b0; bus.we_rt = 1'b0;
        cycle();
        check("lf_readback", bus.dout_lf, LfConst);
        bus.we_lf = 1'b1; bus.din_lf = ~LfConst;
        cycle();
        check("lf_read_before_write", bus.dout_lf, LfConst);
        bus.we_lf = 1'b0;
        cycle();
        check("lf_new_value", bus.dout_lf, ~LfConst);

        // Forward predict on lane 0, other lanes pass through.
        bus.sam_s_i = rnd144();
        bus.left_s_i[8:0] = 9'h0a4; bus.sam_s_i[8:0] = 9'h0a4; bus.right_s_i[8:0] = 9'h0a4;
        bus.flgs_s_i = 80'd7; bus.update_s = 1'b1;
        cycle();
        check("fwd_predict_lane0", 144'(bus.flat_sa[8:0]), 144'd0);
        check("passthru_lanes", 144'(bus.flat_sa[143:9]), 144'(bus.sam_s_i[143:9]));
        check("noupdate_low", 144'(bus.noupdate_s), 144'(1'b0));
        bus.update_s = 1'b0;
        cycle();
        check("noupdate_back", 144'(bus.noupdate_s), 144'(1'b1));

        // Forward and inverse update.
        bus.left_s_i[8:0] = 9'd4; bus.right_s_i[8:0] = 9'd6; bus.sam_s_i[8:0] = 9'd10;
        bus.flgs_s_i = 80'd5; bus.update_s = 1'b1;
        cycle();
        check("fwd_update", 144'(bus.flat_sa[8:0]), 144'd13);
        bus.flgs_s_i = 80'd4;
        cycle();
        check("inv_update", 144'(bus.flat_sa[8:0]), 144'd7);

        // Back-to-back requests with random data.
        for (int i = 0; i < 3; i++) begin
            bus.left_s_i = rnd144(); bus.sam_s_i = rnd144(); bus.right_s_i = rnd144();
            bus.flgs_s_i = 80'({$urandom, $urandom, $urandom});
            cycle();
        end
        bus.update_s = 1'b0;

        // Significance count and result memory.
        bus.bits_in_sig = 10'h3ff;
        cycle();
        check("vv_all", 144'(bus.vv), 144'd10);
        bus.din_res = bus.vv; bus.addr_res = 10'd7; bus.we_res = 1'b1;
        cycle();
        bus.we_res = 1'b0;
        cycle();
        check("res_readback10", 144'(bus.dout_res), 144'd10);
        bus.bits_in_sig = 10'h3fe;
        cycle();
        check("vv_nine", 144'(bus.vv), 144'd9);
        bus.din_res = bus.vv; bus.we_res = 1'b1;
        cycle();
        bus.we_res = 1'b0;
        cycle();
        check("res_readback9", 144'(bus.dout_res), 144'd9);

        // Row limit suppresses the request.
        bus.row_ind = 10'd16; bus.ma_row = 4'd4; bus.update_s = 1'b1;
        bus.sam_s_i = rnd144(); bus.flgs_s_i = 80'({$urandom, $urandom, $urandom});
        cycle();
        check("suppressed_noupdate", 144'(bus.noupdate_s), 144'(1'b1));
        bus.row_ind = 10'd0;

        // Left image edge.
        bus.col_ind = 10'd0; bus.ma_col = 4'd4;
        bus.left_s_i[8:0] = 9'd0; bus.right_s_i[8:0] = 9'd8; bus.sam_s_i[8:0] = 9'd8;
        bus.flgs_s_i = 80'd7;
        cycle();
`ifdef JPEG_EDGE_MIRROR_EN
        check("edge_left", 144'(bus.flat_sa[8:0]), 144'd0);
`else
        check("edge_left", 144'(bus.flat_sa[8:0]), 144'd4);
`endif
        bus.update_s = 1'b0; bus.col_ind = 10'd5; bus.ma_col = 4'd9;

        // Coordinate wrap-around.
        bus.x = 10'h3ff; bus.z = 9'h001;
        cycle();
        check("coord_wrap", 144'(bus.res_out_x), 144'd0);

        // Reset beats a coincident request.
        bus.update_s = 1'b1; bus.sam_s_i = rnd144(); rst_n = 1'b0;
        cycle();
        check("rst_during_update", bus.flat_sa, 144'd0);
        rst_n = 1'b1; bus.update_s = 1'b0;
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            bus.left_s_i = rnd144(); bus.sam_s_i = rnd144(); bus.right_s_i = rnd144();
            bus.flgs_s_i = 80'({$urandom, $urandom, $urandom});
            bus.update_s = ($urandom_range(0, 3) != 0);
            bus.ma_row = 4'($urandom_range(3, 11));
            bus.row_ind = 10'($urandom_range(0, 1023));
            bus.ma_col = 4'($urandom_range(0, 10));
            case ($urandom_range(0, 2))
                0: bus.col_ind = 10'd0;
                1: bus.col_ind = 10'((1 << int'(bus.ma_col)) - 1);
                default: bus.col_ind = 10'($urandom_range(0, 1023));
            endcase
            bus.x = 10'($urandom); bus.z = 9'($urandom); bus.bits_in_sig = 10'($urandom);
            bus.addr_lf = 10'($urandom_range(0, 3)); bus.we_lf = 1'($urandom);
            bus.addr_sa = 10'($urandom_range(0, 3)); bus.we_sa = 1'($urandom);
            bus.addr_rt = 10'($urandom_range(0, 3)); bus.we_rt = 1'($urandom);
            bus.din_lf = rnd144(); bus.din_sa = rnd144(); bus.din_rt = rnd144();
            bus.addr_res = 10'($urandom_range(0, 3)); bus.we_res = 1'($urandom);
            bus.din_res = 9'($urandom);
            bus.addr_flgs = 10'($urandom_range(0, 3));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
